// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider and the stopwatch divisors.
// Also holds the helper that sizes the channel-index field.
package clk_div_pkg;

   localparam int CH_MAX        = 8;
   localparam int WIDTH_DEFAULT = 20;

   localparam int SLOW_DIV = 1000000;
   localparam int SCAN_DIV = 2048;

   // A single-channel divider still needs a 1-bit index, so out-of-range writes stay expressible.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: divisor register, period counter, tick strobe and square wave.
// A divisor write on this channel takes priority over its terminal count.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int               WIDTH   = WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RST_DIV = WIDTH'(SCAN_DIV)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] div_i,
   output logic             tick_o,
   output logic             sq_o
);

   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   // NOTE: every next-state signal gets a default first, so no path through this block infers a latch.
   always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (wr_i) begin
         div_d = div_i;
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == div_q - WIDTH'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q  <= RST_DIV;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: decodes divisor writes, rejects zero or out-of-range
// writes with a one-cycle cfg_err pulse, and instantiates one clk_div_chan per channel.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int                      WIDTH       = WIDTH_DEFAULT,
   parameter int                      NUM_CH      = 2,
   parameter logic [NUM_CH*WIDTH-1:0] DIV_DEFAULT =
      ((NUM_CH*WIDTH)'(SLOW_DIV) << WIDTH) | (NUM_CH*WIDTH)'(SCAN_DIV)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic                          cfg_we_i,
   input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch_i,
   input  logic [WIDTH-1:0]              cfg_div_i,
   output logic                          cfg_err_o,
   output logic [NUM_CH-1:0]             tick_o,
   output logic [NUM_CH-1:0]             sq_o
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   logic              cfg_ok;
   logic [NUM_CH-1:0] wr;
   logic              cfg_err_q, cfg_err_d;

   assign cfg_ok    = cfg_we_i && (32'(cfg_ch_i) < NUM_CH) && (cfg_div_i != '0);
   assign cfg_err_d = cfg_we_i && !cfg_ok;

   always_ff @(posedge clk_i) begin
      if (rst_i) cfg_err_q <= 1'b0;
      else       cfg_err_q <= cfg_err_d;
   end

   assign cfg_err_o = cfg_err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign wr[g] = cfg_ok && (cfg_ch_i == CH_W'(g));

      clk_div_chan #(
         .WIDTH   (WIDTH),
         .RST_DIV (DIV_DEFAULT[g*WIDTH +: WIDTH])
      ) u_chan (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .en_i   (en_i),
         .wr_i   (wr[g]),
         .div_i  (cfg_div_i),
         .tick_o (tick_o[g]),
         .sq_o   (sq_o[g])
      );
   end

endmodule
